// File: rtl/ring_buffer_arbiter.sv
// ring_buffer_arbiter: sequencer and round-robin arbiter in front of the shared
// ring buffer. Owns occupancy (count/full/empty), drives the buffer's reset,
// enable and push/pop strobes, and qualifies its read data.
// Optional feature macro: RB_ARB_STATS_EN adds a saturating stall_cnt output.
module ring_buffer_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         wr_req,
  input  logic [NREQ*WIDTH-1:0]   wr_data,
  output logic [NREQ-1:0]         wr_gnt,
  input  logic                    rd_req,
  output logic                    rd_gnt,
  output logic                    rd_valid,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [CW-1:0]           count,
  output logic                    buf_reset,
  output logic                    buf_enable,
  output logic                    buf_push,
  output logic                    buf_pop,
  output logic [WIDTH-1:0]        buf_datain,
  input  logic [WIDTH-1:0]        buf_dataout
`ifdef RB_ARB_STATS_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int PW1 = PW + 1;

  typedef enum logic {
    OP_POP  = 1'b0,
    OP_PUSH = 1'b1
  } op_e;

  logic            init_q, init_d;
  logic [CW-1:0]   count_q, count_d;
  op_e             last_op_q, last_op_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            rd_valid_q, rd_valid_d;

  logic            full_w;
  logic            empty_w;
  logic            can_push;
  logic            can_pop;
  logic            do_push;
  logic            do_pop;
  logic            sel_found;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   cand;
  logic [PW:0]     cand_wide;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // Round-robin search: scan producers starting at rr_ptr, first requester wins
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_wide = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_wide = {1'b0, rr_ptr_q} + PW1'(k);
      if (cand_wide >= PW1'(NREQ)) begin
        cand_wide = cand_wide - PW1'(NREQ);
      end
      cand = cand_wide[PW-1:0];
      if (!sel_found && wr_req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Pick one operation per cycle; contention alternates against the last op
  always_comb begin
    can_pop  = init_q & rd_req & ~empty_w;
    can_push = init_q & (|wr_req) & ~full_w & sel_found;
    do_pop   = can_pop & (~can_push | (last_op_q == OP_PUSH));
    do_push  = can_push & ~do_pop;
  end

  // Grant and buffer-side strobes follow the decision in the same cycle
  always_comb begin
    wr_gnt     = '0;
    buf_datain = '0;
    if (do_push) begin
      wr_gnt[sel_idx] = 1'b1;
      buf_datain      = wr_data[sel_idx*WIDTH +: WIDTH];
    end
    rd_gnt   = do_pop;
    buf_pop  = do_pop;
    buf_push = do_push;
  end

  // Next-state for init, occupancy, alternation, rotation and read-valid
  always_comb begin
    init_d     = 1'b1;
    count_d    = count_q;
    last_op_d  = last_op_q;
    rr_ptr_d   = rr_ptr_q;
    rd_valid_d = do_pop;
    if (do_push) begin
      count_d   = count_q + CW'(1);
      last_op_d = OP_PUSH;
      if (sel_idx == PW'(NREQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = sel_idx + PW'(1);
      end
    end else if (do_pop) begin
      count_d   = count_q - CW'(1);
      last_op_d = OP_POP;
    end
  end

  // State registers; reset discards occupancy and any pending read-valid
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      init_q     <= 1'b0;
      count_q    <= '0;
      last_op_q  <= OP_PUSH;
      rr_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      init_q     <= init_d;
      count_q    <= count_d;
      last_op_q  <= last_op_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign full       = full_w;
  assign empty      = empty_w;
  assign count      = count_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = buf_dataout;
  assign buf_reset  = ~init_q;
  assign buf_enable = init_q;

`ifdef RB_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a producer is blocked by a full buffer, saturating
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (init_q && (|wr_req) && full_w && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
